// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file arbiter slice.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 4;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } stateT;

    typedef enum logic {
        REQ_A,
        REQ_B
    } reqIdT;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer names the port that wins a tie
// and moves to the other port after every grant.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    reqIdT ptr;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr == REQ_A) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ptr <= REQ_A;
        end else if (gnt[0]) begin
            ptr <= REQ_B;
        end else if (gnt[1]) begin
            ptr <= REQ_A;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register file's write port and Rs read port between the core
// (port A) and the debug/loader unit (port B), after clearing R0..R3 at reset.
module regfile_arbiter #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] rf_rs,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_regwrite,
    input  logic [DATA_W-1:0] rf_read_rs,
    output logic              init_done
);

    import regfile_pkg::*;

    stateT             state;
    stateT             nextState;
    logic [ADDR_W-1:0] initCnt;
    logic [1:0]        gnt;
    logic              anyGnt;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              rdPending;
    reqIdT             rdId;

    rr_arbiter2 u_arb (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .enable  (state == ST_RUN),
        .req     ({b_req, a_req}),
        .gnt     (gnt)
    );

    assign a_gnt     = gnt[0];
    assign b_gnt     = gnt[1];
    assign anyGnt    = |gnt;
    assign init_done = (state == ST_RUN);

    always_comb begin
        selWe    = a_we;
        selAddr  = a_addr;
        selWdata = a_wdata;
        if (gnt[1]) begin
            selWe    = b_we;
            selAddr  = b_addr;
            selWdata = b_wdata;
        end
    end

    always_comb begin
        nextState = state;
        if (state == ST_INIT && initCnt == ADDR_W'(NUM_REGS - 1)) begin
            nextState = ST_RUN;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state   <= ST_INIT;
            initCnt <= '0;
        end else begin
            state <= nextState;
            if (state == ST_INIT) begin
                initCnt <= initCnt + 1'b1;
            end
        end
    end

    // Register-file command stage: init clears one register per cycle, then
    // the granted request drives either the write port or the Rs select.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            rf_rs       <= '0;
            rf_rd       <= '0;
            rf_wdata    <= '0;
            rf_regwrite <= 1'b0;
        end else if (state == ST_INIT) begin
            rf_rd       <= initCnt;
            rf_wdata    <= '0;
            rf_regwrite <= 1'b1;
        end else begin
            rf_regwrite <= anyGnt & selWe;
            if (anyGnt && selWe) begin
                rf_rd    <= selAddr;
                rf_wdata <= selWdata;
            end
            if (anyGnt && !selWe) begin
                rf_rs <= selAddr;
            end
        end
    end

    // Read return: ReadRs is valid the cycle after rf_rs is registered.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            rdPending <= 1'b0;
            rdId      <= REQ_A;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            rdPending <= anyGnt & ~selWe;
            rdId      <= gnt[1] ? REQ_B : REQ_A;
            a_rvalid  <= rdPending && (rdId == REQ_A);
            b_rvalid  <= rdPending && (rdId == REQ_B);
            if (rdPending && rdId == REQ_A) begin
                a_rdata <= rf_read_rs;
            end
            if (rdPending && rdId == REQ_B) begin
                b_rdata <= rf_read_rs;
            end
        end
    end

endmodule
